// File: rtl/alu_exec_unit.sv
// alu_exec_unit: integer ALU with single-cycle logic/arith/shift/compare ops
// and a multi-cycle shift-add multiplier, behind a valid/ready handshake.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   in_valid/in_ready  request handshake (alu_control, operand_a, operand_b)
//   out_valid/out_ready result handshake (result, zero)
//   busy               high while a multiply is iterating
//
// Single-cycle ops return one cycle after accept and can stream at one per
// cycle. MUL takes XLEN iterations, then parks in HOLD until retired.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic [1:0] {IDLE, MUL_RUN, HOLD} state_t;

    state_t          state;
    logic [SW-1:0]   cnt;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] step_sum;
    logic [SW-1:0]   shamt;
    logic            accept;

    assign shamt    = operand_b[SW-1:0];
    // A held result may be retired in the same cycle a new op is accepted.
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign step_sum = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        alu_res = '0;
        case (alu_control)
            4'b0000: alu_res = operand_a & operand_b;
            4'b0001: alu_res = operand_a | operand_b;
            4'b0010: alu_res = operand_a + operand_b;
            4'b0011: alu_res = operand_a ^ operand_b;
            4'b0100: alu_res = operand_a << shamt;
            4'b0101: alu_res = operand_a >> shamt;
            4'b0110: alu_res = operand_a - operand_b;
            4'b0111: alu_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            4'b1000: alu_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            4'b1001: alu_res = $unsigned($signed(operand_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (alu_control == OP_MUL) begin
                            // Operands are latched so later input changes cannot disturb the product.
                            mcand     <= operand_a;
                            mplier    <= operand_b;
                            acc       <= '0;
                            cnt       <= '0;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            state     <= MUL_RUN;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL_RUN: begin
                    acc    <= step_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SW'(XLEN-1)) begin
                        result    <= step_sum;
                        zero      <= (step_sum == '0);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      alu_control = 4'd0;
    logic [XLEN-1:0] operand_a = '0;
    logic [XLEN-1:0] operand_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int rdy_mode = 0;  // 0: out_ready=1, 1: out_ready=0, 2: random

    typedef struct {
        logic [XLEN-1:0] res;
        int              acc_cyc;
        int              lat;
    } exp_t;
    exp_t q[$];
    exp_t me;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: straight arithmetic on the operation definitions.
    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        int sh;
        sh = int'(b % XLEN);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return a << sh;
            4'd5:  return a >> sh;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 1 : 0;
            4'd8:  return (a < b) ? 1 : 0;
            4'd9:  return $unsigned($signed(a) >>> sh);
            4'd10: return XLEN'(a * b);
            default: return '0;
        endcase
    endfunction

    // Monitor: pops the scoreboard whenever a fresh result appears, and checks
    // that a stalled result stays put.
    logic            pv = 1'b0, pf = 1'b0, prst = 1'b1, pz = 1'b1;
    logic [XLEN-1:0] pres = '0;
    always @(negedge clk) begin
        if (!prst) begin
            if (out_valid && (!pv || pf)) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    me = q.pop_front();
                    check("result", result, me.res);
                    check("zero", zero, me.res == '0);
                    check("latency", cyc - me.acc_cyc, me.lat);
                end
            end else if (pv && !pf) begin
                check("hold_valid", out_valid, 1);
                check("hold_result", result, pres);
                check("hold_zero", zero, pz);
            end
        end
        pv   = out_valid;
        pf   = out_valid && out_ready;
        pres = result;
        pz   = zero;
        prst = rst;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a request until accepted; returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input bit push, output int acc_cyc);
        bit   acc;
        exp_t e;
        acc = 0;
        acc_cyc = -1;
        in_valid = 1'b1;
        alu_control = op;
        operand_a = a;
        operand_b = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                acc_cyc = cyc;
                if (push) begin
                    e.res = ref_alu(op, a, b);
                    e.acc_cyc = cyc;
                    e.lat = (op == 4'd10) ? XLEN + 1 : 1;
                    q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, cprev;
        logic [XLEN-1:0] ra, rb;
        logic [3:0] rop;

        // Reset with a request pending: it must be ignored.
        rst = 1'b1;
        in_valid = 1'b1;
        alu_control = 4'd2;
        operand_a = 32'd7;
        operand_b = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        issue(4'd2, 32'd7, 32'd5, 1, c);
        issue(4'd6, 32'd5, 32'd5, 1, c);
        issue(4'd9, 32'h8000_0000, 32'd4, 1, c);
        issue(4'd5, 32'h8000_0000, 32'd4, 1, c);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1, 1, c);
        issue(4'd8, 32'hFFFF_FFFF, 32'd1, 1, c);
        issue(4'd4, 32'h0000_0001, 32'h0000_0123, 1, c);
        issue(4'd15, 32'h1234_5678, 32'h1, 1, c);
        cycles(2);

        // MUL with consumer stalled: busy for XLEN cycles, in_ready low until retired.
        rdy_mode = 1;
        cycles(1);
        issue(4'd10, 32'h0000_1234, 32'h0000_0010, 1, c);
        for (int i = 1; i <= XLEN; i++) begin
            @(negedge clk);
            check("mul_busy", busy, 1);
            check("mul_in_ready", in_ready, 0);
            check("mul_out_valid_early", out_valid, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("mul_done_busy", busy, 0);
        check("mul_done_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("hold_in_ready", in_ready, 0);
        end
        rdy_mode = 0;
        cycles(1);
        @(negedge clk);
        check("hold_retire_in_ready", in_ready, 0);
        cycles(1);
        @(negedge clk);
        check("after_mul_valid", out_valid, 0);
        check("after_mul_in_ready", in_ready, 1);
        cycles(1);

        // ADD with 5 cycles of backpressure.
        rdy_mode = 1;
        cycles(1);
        issue(4'd2, 32'd100, 32'd23, 1, c);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        cycles(1);
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        cycles(1);
        @(negedge clk);
        check("bp_retired_valid", out_valid, 0);
        cycles(1);

        // Four back-to-back ADDs: accepted on consecutive cycles.
        cprev = -1;
        for (int i = 0; i < 4; i++) begin
            issue(4'd2, $urandom, $urandom, 1, c);
            if (i > 0) check("stream_gap", c - cprev, 1);
            cprev = c;
        end
        cycles(2);

        // Reset at MUL iteration 10: product must never appear.
        issue(4'd10, $urandom, $urandom, 0, c);
        cycles(10);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy_before", busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_zero", zero, 1);
        check("abort_in_ready", in_ready, 1);
        cycles(1);
        issue(4'd2, 32'd3, 32'd4, 1, c);
        cycles(40);
        check("abort_queue_empty", q.size(), 0);

        // Randomized traffic with a random consumer.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = 32'($urandom_range(0, 40));
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb, 1, c);
            cycles($urandom_range(0, 2));
        end
        rdy_mode = 0;
        for (int i = 0; i < 100 && q.size() != 0; i++) cycles(1);
        check("drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
